// File: rtl/alu_operand_stage_if.sv
// Bundle of the upstream/downstream handshake, operand and forwarding signals
// around the ALU operand stage.
interface alu_operand_stage_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [31:0] imm_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic        alu_src_i;
  logic [3:0]  ctrl_i;
  logic        exmem_wen_i;
  logic        memwb_wen_i;
  logic [4:0]  exmem_addr_i;
  logic [4:0]  memwb_addr_i;
  logic [31:0] exmem_data_i;
  logic [31:0] memwb_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic [3:0]  ctrl_o;
  logic        illegal_o;

  modport slave (
    input  in_valid_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i,
           alu_src_i, ctrl_i, exmem_wen_i, memwb_wen_i, exmem_addr_i,
           memwb_addr_i, exmem_data_i, memwb_data_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, illegal_o
  );

  modport master (
    output in_valid_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i,
           alu_src_i, ctrl_i, exmem_wen_i, memwb_wen_i, exmem_addr_i,
           memwb_addr_i, exmem_data_i, memwb_data_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, illegal_o
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves forwarding at accept time and holds results in a
// two-entry skid buffer (OUT + SKID) so in_ready never depends on out_ready.
module alu_operand_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic        illegal;
  } entry_t;

  entry_t out_q, skid_q, in_entry;
  logic   out_valid_q, skid_valid_q;
  logic   accept, out_fire;

  // EX/MEM wins over MEM/WB; r0 is never forwarded.
  function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] reg_data);
    logic [31:0] r;
    r = reg_data;
    if (FWD_EN && addr != 5'd0) begin
      if (bus.exmem_wen_i && bus.exmem_addr_i == addr)
        r = bus.exmem_data_i;
      else if (bus.memwb_wen_i && bus.memwb_addr_i == addr)
        r = bus.memwb_data_i;
    end
    return r;
  endfunction

  always_comb begin
    in_entry.src1    = fwd_sel(bus.rs_addr_i, bus.rs_data_i);
    in_entry.src2    = bus.alu_src_i ? bus.imm_i : fwd_sel(bus.rt_addr_i, bus.rt_data_i);
    in_entry.ctrl    = bus.ctrl_i;
    in_entry.illegal = !(bus.ctrl_i inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12});
  end

  assign bus.in_ready_o = !rst_i && !skid_valid_q;
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign out_fire       = out_valid_q && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (bus.flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= in_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.out_valid_o = out_valid_q && !rst_i;
  assign bus.src1_o      = out_q.src1;
  assign bus.src2_o      = out_q.src2;
  assign bus.ctrl_o      = out_q.ctrl;
  assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: pass-through, forwarding priority,
// immediate/illegal decode, backpressure ordering, flush and reset.
module tb_alu_operand_stage;
  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  alu_operand_stage_if bus ();

  alu_operand_stage #(.FWD_EN(1'b1)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] ctrl);
    bus.in_valid_i = 1'b1;
    bus.rs_data_i  = rs;
    bus.rt_data_i  = rt;
    bus.ctrl_i     = ctrl;
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.rs_data_i    = '0;
    bus.rt_data_i    = '0;
    bus.imm_i        = '0;
    bus.rs_addr_i    = 5'd1;
    bus.rt_addr_i    = 5'd2;
    bus.alu_src_i    = 1'b0;
    bus.ctrl_i       = '0;
    bus.exmem_wen_i  = 1'b0;
    bus.memwb_wen_i  = 1'b0;
    bus.exmem_addr_i = '0;
    bus.memwb_addr_i = '0;
    bus.exmem_data_i = '0;
    bus.memwb_data_i = '0;
    bus.flush_i      = 1'b0;
    bus.out_ready_i  = 1'b1;

    step();
    step();
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_src1", bus.src1_o, 0);
    chk("rst_src2", bus.src2_o, 0);
    chk("rst_ctrl", bus.ctrl_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready_o, 1);

    // Pass-through
    op(32'd5, 32'd7, 4'd2);
    step();
    chk("pt_valid", bus.out_valid_o, 1);
    chk("pt_src1", bus.src1_o, 32'd5);
    chk("pt_src2", bus.src2_o, 32'd7);
    chk("pt_ctrl", bus.ctrl_o, 32'd2);
    chk("pt_illegal", bus.illegal_o, 0);
    bus.in_valid_i = 1'b0;
    step();
    chk("pt_drained", bus.out_valid_o, 0);

    // Forwarding, back-to-back ops
    op(32'h11, 32'h22, 4'd0);
    bus.rs_addr_i    = 5'd3;
    bus.exmem_wen_i  = 1'b1; bus.exmem_addr_i = 5'd3; bus.exmem_data_i = 32'hAA;
    bus.memwb_wen_i  = 1'b1; bus.memwb_addr_i = 5'd3; bus.memwb_data_i = 32'hBB;
    step();
    chk("fwd_exmem_prio", bus.src1_o, 32'hAA);
    bus.exmem_wen_i = 1'b0;
    step();
    chk("fwd_memwb", bus.src1_o, 32'hBB);
    chk("fwd_tput_valid", bus.out_valid_o, 1);
    bus.exmem_wen_i = 1'b1; bus.exmem_addr_i = 5'd0;
    bus.memwb_addr_i = 5'd0; bus.rs_addr_i = 5'd0;
    step();
    chk("fwd_r0_never", bus.src1_o, 32'h11);
    bus.rt_addr_i = 5'd4; bus.exmem_addr_i = 5'd3;
    bus.memwb_addr_i = 5'd4; bus.memwb_data_i = 32'hCC;
    step();
    chk("fwd_rt_memwb", bus.src2_o, 32'hCC);

    // Immediate overrides forwarding; illegal decode
    bus.alu_src_i = 1'b1; bus.imm_i = 32'hFFFF_FFFC;
    bus.exmem_addr_i = 5'd4; bus.ctrl_i = 4'd4;
    step();
    chk("imm_src2", bus.src2_o, 32'hFFFF_FFFC);
    chk("imm_illegal", bus.illegal_o, 1);
    chk("imm_ctrl", bus.ctrl_o, 32'd4);
    bus.ctrl_i = 4'd12;
    step();
    chk("legal_12", bus.illegal_o, 0);
    bus.ctrl_i = 4'd13;
    step();
    chk("illegal_13", bus.illegal_o, 1);
    bus.alu_src_i = 1'b0; bus.exmem_wen_i = 1'b0; bus.memwb_wen_i = 1'b0;
    bus.in_valid_i = 1'b0;
    step();

    // Backpressure: A, B fill the buffer, C held off, then drain in order
    bus.out_ready_i = 1'b0;
    bus.rs_addr_i = 5'd1; bus.rt_addr_i = 5'd2;
    op(32'hA, 32'h1, 4'd0);
    step();
    chk("bp_A_out", bus.src1_o, 32'hA);
    chk("bp_ready_A", bus.in_ready_o, 1);
    op(32'hB, 32'h2, 4'd1);
    step();
    chk("bp_A_held", bus.src1_o, 32'hA);
    chk("bp_ready_B", bus.in_ready_o, 0);
    op(32'hC, 32'h3, 4'd6);
    step();
    chk("bp_A_stable", bus.src1_o, 32'hA);
    chk("bp_A_ctrl_stable", bus.ctrl_o, 32'd0);
    chk("bp_C_blocked", bus.in_ready_o, 0);
    bus.out_ready_i = 1'b1;
    step();
    chk("bp_B_out", bus.src1_o, 32'hB);
    chk("bp_B_ctrl", bus.ctrl_o, 32'd1);
    chk("bp_ready_again", bus.in_ready_o, 1);
    step();
    chk("bp_C_out", bus.src1_o, 32'hC);
    chk("bp_C_valid", bus.out_valid_o, 1);
    bus.in_valid_i = 1'b0;
    step();
    chk("bp_empty", bus.out_valid_o, 0);

    // Flush with both entries full and an input presented
    bus.out_ready_i = 1'b0;
    op(32'hD, 32'h4, 4'd7);
    step();
    op(32'hE, 32'h5, 4'd7);
    step();
    chk("fl_full", bus.in_ready_o, 0);
    op(32'hF, 32'h6, 4'd7);
    bus.flush_i = 1'b1;
    step();
    chk("fl_out_valid", bus.out_valid_o, 0);
    chk("fl_in_ready", bus.in_ready_o, 1);
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    step();
    chk("fl_input_dropped", bus.out_valid_o, 0);

    // Reset with both entries full, overriding flush and input
    op(32'h10, 32'h7, 4'd4);
    step();
    op(32'h20, 32'h8, 4'd4);
    step();
    chk("rr_full", bus.in_ready_o, 0);
    rst_i = 1'b1; bus.flush_i = 1'b1;
    step();
    chk("rr_out_valid", bus.out_valid_o, 0);
    chk("rr_in_ready", bus.in_ready_o, 0);
    chk("rr_src1", bus.src1_o, 0);
    chk("rr_src2", bus.src2_o, 0);
    chk("rr_ctrl", bus.ctrl_o, 0);
    chk("rr_illegal", bus.illegal_o, 0);
    rst_i = 1'b0; bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    step();
    chk("rr_after_ready", bus.in_ready_o, 1);
    chk("rr_after_empty", bus.out_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
